// File: rtl/lpm_mac_pipe.sv
// lpm_mac_pipe: pipelined multiply-accumulate, result = dataa*datab + addend.
// The addend is either the sum input or the previous result (running accumulation).
// It has a valid/ready handshake with full backpressure and signed/unsigned operands.
// It also has an overflow flag and optional saturation.
//
// Ports:
//   clock      rising-edge clock
//   sclr       synchronous active-high reset; has priority over every other input
//   in_valid   dataa/datab/sum/acc valid this cycle
//   in_ready   block accepts input this cycle (combinational)
//   dataa      multiplicand, lpm_widtha bits
//   datab      multiplier, lpm_widthb bits
//   sum        addend when acc=0, lpm_widths bits
//   acc        1: addend = previous result; 0: addend = sum
//   out_valid  result valid
//   out_ready  downstream accepts result
//   result     dataa*datab + addend, wrapped or saturated to lpm_widthp bits
//   overflow   exact result did not fit lpm_widthp (qualified by out_valid)
module lpm_mac_pipe #(
    parameter int unsigned lpm_widtha   = 16,
    parameter int unsigned lpm_widthb   = 16,
    parameter int unsigned lpm_widths   = 32,
    parameter int unsigned lpm_widthp   = 32,
    parameter int unsigned lpm_pipeline = 3,
    parameter int unsigned lpm_signed   = 1,
    parameter int unsigned lpm_saturate = 0
) (
    input  logic                  clock,
    input  logic                  sclr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [lpm_widtha-1:0] dataa,
    input  logic [lpm_widthb-1:0] datab,
    input  logic [lpm_widths-1:0] sum,
    input  logic                  acc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [lpm_widthp-1:0] result,
    output logic                  overflow
);

    localparam int unsigned PW  = lpm_widtha + lpm_widthb;
    // Wide enough that product + addend can never wrap, so overflow is exact.
    localparam int unsigned FW  = lpm_widthp + PW + lpm_widths + 1;
    localparam bit          Sgn = (lpm_signed != 0);
    localparam bit          Sat = (lpm_saturate != 0);

    localparam logic [lpm_widthp-1:0] SMin = lpm_widthp'(1) << (lpm_widthp - 1);
    localparam logic [lpm_widthp-1:0] SMax = ~SMin;

    logic advance;
    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    // Both operands are extended to the full product width first, so a plain
    // truncating multiply gives the exact two's-complement or unsigned product.
    function automatic logic [PW-1:0] mul(input logic [lpm_widtha-1:0] a,
                                          input logic [lpm_widthb-1:0] b);
        logic [PW-1:0] ea;
        logic [PW-1:0] eb;
        ea = {{lpm_widthb{Sgn & a[lpm_widtha-1]}}, a};
        eb = {{lpm_widtha{Sgn & b[lpm_widthb-1]}}, b};
        return ea * eb;
    endfunction

    // Item feeding the output register this cycle.
    logic                  f_valid;
    logic [PW-1:0]         f_prod;
    logic [lpm_widths-1:0] f_sum;
    logic                  f_acc;

    if (lpm_pipeline == 1) begin : g_comb
        assign f_valid = in_valid;
        assign f_prod  = mul(dataa, datab);
        assign f_sum   = sum;
        assign f_acc   = acc;
    end else begin : g_pipe
        localparam int unsigned NS = lpm_pipeline - 1;

        logic [NS-1:0]         vld_q;
        logic [NS-1:0]         acc_q;
        logic [PW-1:0]         prod_q [NS];
        logic [lpm_widths-1:0] sum_q  [NS];

        always_ff @(posedge clock) begin
            if (sclr) begin
                vld_q <= '0;
            end else if (advance) begin
                vld_q[0] <= in_valid;
                for (int i = 1; i < NS; i++) vld_q[i] <= vld_q[i-1];
            end
        end

        // Payload is only meaningful alongside vld_q, so it needs no reset.
        always_ff @(posedge clock) begin
            if (advance) begin
                prod_q[0] <= mul(dataa, datab);
                sum_q[0]  <= sum;
                acc_q[0]  <= acc;
                for (int i = 1; i < NS; i++) begin
                    prod_q[i] <= prod_q[i-1];
                    sum_q[i]  <= sum_q[i-1];
                    acc_q[i]  <= acc_q[i-1];
                end
            end
        end

        assign f_valid = vld_q[NS-1];
        assign f_prod  = prod_q[NS-1];
        assign f_sum   = sum_q[NS-1];
        assign f_acc   = acc_q[NS-1];
    end

    logic                  out_valid_q;
    logic [lpm_widthp-1:0] result_q;
    logic                  overflow_q;

    logic [FW-1:0]         prod_x;
    logic [FW-1:0]         add_x;
    logic [FW-1:0]         full;
    logic                  ovf_d;
    logic [lpm_widthp-1:0] res_d;

    always_comb begin
        prod_x = {{(FW - PW){Sgn & f_prod[PW-1]}}, f_prod};
        // The addend is read from result_q as the item enters the output register,
        // so back-to-back accumulate items chain without a hazard.
        if (f_acc) begin
            add_x = {{(FW - lpm_widthp){Sgn & result_q[lpm_widthp-1]}}, result_q};
        end else begin
            add_x = {{(FW - lpm_widths){Sgn & f_sum[lpm_widths-1]}}, f_sum};
        end
        full = prod_x + add_x;

        // Signed: in range iff every bit from the result sign bit upwards agrees.
        if (Sgn) begin
            ovf_d = !((&full[FW-1:lpm_widthp-1]) | ~(|full[FW-1:lpm_widthp-1]));
        end else begin
            ovf_d = |full[FW-1:lpm_widthp];
        end

        if (ovf_d && Sat) begin
            res_d = Sgn ? (full[FW-1] ? SMin : SMax) : '1;
        end else begin
            res_d = full[lpm_widthp-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
        end else if (advance) begin
            out_valid_q <= f_valid;
            // Bubbles leave the accumulator untouched.
            if (f_valid) begin
                result_q   <= res_d;
                overflow_q <= ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_lpm_mac_pipe.sv
// Testbench for lpm_mac_pipe: five configurations driven with directed and random items.
// Expected results come from an arithmetic reference model and go through per-instance queues.
module tb_lpm_mac_pipe;

    localparam int NI = 5;
    localparam int CWA [NI] = '{16, 8, 8, 8, 8};
    localparam int CWB [NI] = '{16, 8, 8, 8, 8};
    localparam int CWS [NI] = '{32, 16, 8, 8, 12};
    localparam int CWP [NI] = '{32, 16, 8, 8, 12};
    localparam int CP  [NI] = '{3, 3, 1, 1, 1};
    localparam int CSG [NI] = '{1, 0, 1, 1, 0};
    localparam int CST [NI] = '{0, 0, 1, 0, 1};

    logic        clock;
    logic        sclr;
    logic [15:0] a_s   [NI];
    logic [15:0] b_s   [NI];
    logic [31:0] s_s   [NI];
    logic        acc_s [NI];
    logic        iv    [NI];
    logic        ordy  [NI];
    logic        ir    [NI];
    logic        ov    [NI];
    logic        ovf   [NI];
    logic [31:0] r0;
    logic [15:0] r1;
    logic [7:0]  r2;
    logic [7:0]  r3;
    logic [11:0] r4;
    logic [31:0] res   [NI];

    always_comb begin
        res[0] = r0;
        res[1] = {16'b0, r1};
        res[2] = {24'b0, r2};
        res[3] = {24'b0, r3};
        res[4] = {20'b0, r4};
    end

    lpm_mac_pipe #(.lpm_widtha(16), .lpm_widthb(16), .lpm_widths(32), .lpm_widthp(32),
                   .lpm_pipeline(3), .lpm_signed(1), .lpm_saturate(0)) u0 (
        .clock(clock), .sclr(sclr), .in_valid(iv[0]), .in_ready(ir[0]),
        .dataa(a_s[0]), .datab(b_s[0]), .sum(s_s[0]), .acc(acc_s[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .result(r0), .overflow(ovf[0]));

    lpm_mac_pipe #(.lpm_widtha(8), .lpm_widthb(8), .lpm_widths(16), .lpm_widthp(16),
                   .lpm_pipeline(3), .lpm_signed(0), .lpm_saturate(0)) u1 (
        .clock(clock), .sclr(sclr), .in_valid(iv[1]), .in_ready(ir[1]),
        .dataa(a_s[1][7:0]), .datab(b_s[1][7:0]), .sum(s_s[1][15:0]), .acc(acc_s[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .result(r1), .overflow(ovf[1]));

    lpm_mac_pipe #(.lpm_widtha(8), .lpm_widthb(8), .lpm_widths(8), .lpm_widthp(8),
                   .lpm_pipeline(1), .lpm_signed(1), .lpm_saturate(1)) u2 (
        .clock(clock), .sclr(sclr), .in_valid(iv[2]), .in_ready(ir[2]),
        .dataa(a_s[2][7:0]), .datab(b_s[2][7:0]), .sum(s_s[2][7:0]), .acc(acc_s[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .result(r2), .overflow(ovf[2]));

    lpm_mac_pipe #(.lpm_widtha(8), .lpm_widthb(8), .lpm_widths(8), .lpm_widthp(8),
                   .lpm_pipeline(1), .lpm_signed(1), .lpm_saturate(0)) u3 (
        .clock(clock), .sclr(sclr), .in_valid(iv[3]), .in_ready(ir[3]),
        .dataa(a_s[3][7:0]), .datab(b_s[3][7:0]), .sum(s_s[3][7:0]), .acc(acc_s[3]),
        .out_valid(ov[3]), .out_ready(ordy[3]), .result(r3), .overflow(ovf[3]));

    lpm_mac_pipe #(.lpm_widtha(8), .lpm_widthb(8), .lpm_widths(12), .lpm_widthp(12),
                   .lpm_pipeline(1), .lpm_signed(0), .lpm_saturate(1)) u4 (
        .clock(clock), .sclr(sclr), .in_valid(iv[4]), .in_ready(ir[4]),
        .dataa(a_s[4][7:0]), .datab(b_s[4][7:0]), .sum(s_s[4][11:0]), .acc(acc_s[4]),
        .out_valid(ov[4]), .out_ready(ordy[4]), .result(r4), .overflow(ovf[4]));

    typedef struct {
        logic [31:0] r;
        logic        o;
    } exp_t;

    exp_t   expq [NI][$];
    longint accst [NI];
    int     bp_mode [NI];
    int     n_vec = 0;
    int     n_bad = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Interpret the low w bits of raw as a signed or unsigned number.
    function automatic longint sx(input longint raw, input int w, input bit sgn);
        longint v;
        v = raw & ((longint'(1) << w) - 1);
        if (sgn && ((v >> (w - 1)) & 1) != 0) v = v - (longint'(1) << w);
        return v;
    endfunction

    // Reference: exact arithmetic, then range check and clamp or wrap.
    task automatic model_push(input int k, input longint a, input longint b, input longint s,
                              input bit acc, input bit use_want, input longint want,
                              input bit want_o);
        longint full, mx, mn, st;
        bit     o;
        int     p;
        exp_t   e;
        p = CWP[k];
        full = sx(a, CWA[k], CSG[k] != 0) * sx(b, CWB[k], CSG[k] != 0)
             + (acc ? accst[k] : sx(s, CWS[k], CSG[k] != 0));
        if (CSG[k] != 0) begin
            mx = (longint'(1) << (p - 1)) - 1;
            mn = -(longint'(1) << (p - 1));
        end else begin
            mx = (longint'(1) << p) - 1;
            mn = 0;
        end
        o = (full > mx) || (full < mn);
        if (o && CST[k] != 0) st = (full > mx) ? mx : mn;
        else                  st = sx(full, p, CSG[k] != 0);
        accst[k] = st;
        e.r = 32'(st & ((longint'(1) << p) - 1));
        e.o = o;
        if (use_want) begin
            e.r = 32'(want & ((longint'(1) << p) - 1));
            e.o = want_o;
        end
        expq[k].push_back(e);
    endtask

    task automatic issue(input int k, input longint a, input longint b, input longint s,
                         input bit acc, input bit use_want, input longint want,
                         input bit want_o);
        int n;
        n = 0;
        a_s[k]   = a[15:0];
        b_s[k]   = b[15:0];
        s_s[k]   = s[31:0];
        acc_s[k] = acc;
        iv[k]    = 1'b1;
        forever begin
            @(negedge clock);
            if (ir[k] || n > 100) break;
            n++;
        end
        if (!ir[k]) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept[%0d]: in_ready stayed 0, required 1", k);
        end else begin
            model_push(k, a, b, s, acc, use_want, want, want_o);
        end
        @(posedge clock);
        #1;
        iv[k] = 1'b0;
    endtask

    task automatic rnd_issue(input int k, input int acc_pct);
        issue(k, longint'($urandom), longint'($urandom), longint'($urandom),
              ($urandom_range(0, 99) < acc_pct), 1'b0, 0, 1'b0);
    endtask

    // Called right after issue(): count cycles from the accept edge to out_valid.
    task automatic latency(input int k);
        int c;
        c = 1;
        while (!ov[k] && c < 20) begin
            @(posedge clock);
            #1;
            c++;
        end
        check($sformatf("latency[%0d]", k), c, CP[k]);
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while ((expq[k].size() != 0 || ov[k]) && n < 400) begin
            @(posedge clock);
            #1;
            n++;
        end
        check($sformatf("drain[%0d] pending", k), expq[k].size(), 0);
    endtask

    task automatic do_reset();
        sclr = 1'b1;
        for (int k = 0; k < NI; k++) iv[k] = 1'b0;
        @(posedge clock);
        #1;
        sclr = 1'b0;
        for (int k = 0; k < NI; k++) begin
            expq[k].delete();
            accst[k] = 0;
        end
    endtask

    // out_ready driver: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
    initial begin
        int ph [NI];
        for (int k = 0; k < NI; k++) ph[k] = 0;
        forever begin
            @(posedge clock);
            #1;
            for (int k = 0; k < NI; k++) begin
                case (bp_mode[k])
                    1:       ordy[k] = (ph[k] == 0);
                    2:       ordy[k] = ($urandom_range(0, 1) == 1);
                    default: ordy[k] = 1'b1;
                endcase
                ph[k] = (ph[k] == 2) ? 0 : ph[k] + 1;
            end
        end
    end

    // Monitors: pop and compare on each output transfer; also check the ready rule
    // and that a stalled output holds its value.
    for (genvar k = 0; k < NI; k++) begin : g_mon
        initial begin
            bit          held_v;
            logic [31:0] held_r;
            exp_t        e;
            held_v = 1'b0;
            held_r = '0;
            forever begin
                @(negedge clock);
                if (sclr) begin
                    held_v = 1'b0;
                end else begin
                    check($sformatf("in_ready[%0d]", k), 32'(ir[k]), 32'(!ov[k] || ordy[k]));
                    if (held_v && ov[k]) check($sformatf("stall hold[%0d]", k), res[k], held_r);
                    if (ov[k] && ordy[k]) begin
                        if (expq[k].size() == 0) begin
                            n_vec++;
                            n_bad++;
                            $display("FAIL extra output[%0d]: got %0h, expected no item", k,
                                     res[k]);
                        end else begin
                            e = expq[k].pop_front();
                            check($sformatf("result[%0d]", k), res[k], e.r);
                            check($sformatf("overflow[%0d]", k), 32'(ovf[k]), 32'(e.o));
                        end
                        held_v = 1'b0;
                    end else if (ov[k]) begin
                        held_v = 1'b1;
                        held_r = res[k];
                    end else begin
                        held_v = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        time t0;
        sclr = 1'b1;
        for (int k = 0; k < NI; k++) begin
            a_s[k] = '0; b_s[k] = '0; s_s[k] = '0; acc_s[k] = 1'b0;
            iv[k] = 1'b0; ordy[k] = 1'b1; bp_mode[k] = 0; accst[k] = 0;
        end
        repeat (2) @(posedge clock);
        #1;
        do_reset();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset out_valid[%0d]", k), 32'(ov[k]), 0);
            check($sformatf("reset result[%0d]", k), res[k], 0);
            check($sformatf("reset overflow[%0d]", k), 32'(ovf[k]), 0);
        end

        // Unsigned 8x8->16, three-stage pipe.
        issue(1, 255, 255, 1, 1'b0, 1'b1, 65026, 1'b0);
        latency(1);
        drain(1);

        // Signed accumulate chain, back to back.
        issue(0, -3, 7, 5, 1'b0, 1'b1, -16, 1'b0);
        issue(0, 2, 2, 0, 1'b1, 1'b1, -12, 1'b0);
        issue(0, -1, 4, 0, 1'b1, 1'b1, -16, 1'b0);
        drain(0);

        // Narrow signed result: saturate vs wrap.
        issue(2, 100, 2, 0, 1'b0, 1'b1, 127, 1'b1);
        latency(2);
        issue(3, 100, 2, 0, 1'b0, 1'b1, -56, 1'b1);
        drain(2);
        drain(3);

        // Backpressure stream.
        bp_mode[0] = 1;
        for (int i = 0; i < 10; i++) rnd_issue(0, 40);
        drain(0);
        bp_mode[0] = 0;

        // Reset with two accumulate items in flight.
        issue(0, 5, 5, 0, 1'b0, 1'b0, 0, 1'b0);
        issue(0, 7, 9, 0, 1'b1, 1'b0, 0, 1'b0);
        issue(0, 2, 3, 0, 1'b1, 1'b0, 0, 1'b0);
        do_reset();
        check("post-reset out_valid", 32'(ov[0]), 0);
        check("post-reset result", res[0], 0);
        issue(0, 3, 3, 0, 1'b1, 1'b1, 9, 1'b0);
        drain(0);

        // Single-cycle pipe at full rate: one accept per cycle.
        for (int k = 2; k < NI; k++) begin
            issue(k, 200, 200, 0, 1'b0, 1'b0, 0, 1'b0);
            latency(k);
            t0 = $time;
            for (int i = 0; i < 20; i++) rnd_issue(k, 30);
            check($sformatf("full rate[%0d]", k), 32'(($time - t0) / 10), 20);
            drain(k);
        end

        // Random traffic with random backpressure and idle gaps.
        for (int k = 0; k < NI; k++) begin
            bp_mode[k] = 2;
            for (int i = 0; i < 40; i++) begin
                rnd_issue(k, 25);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clock);
                    #1;
                end
            end
            drain(k);
            bp_mode[k] = 0;
        end

        for (int k = 0; k < NI; k++) check($sformatf("final queue[%0d]", k), expq[k].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
